if_fetch_unit: RTL
==================

# if_fetch_unit

Instruction-fetch stage that produces what the IF/ID pipeline register captures. Owns the program counter, drives the instruction-memory address, and generates `IF_take`, the per-instruction taken prediction for conditional branches. Redirects the PC on EX/MEM flush and on ID/EX jumps, and holds the PC on stall. An optional 2-bit branch history table provides the predictions.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `BHT_ENTRIES`, default 64: number of BHT counters; must be a power of 2, minimum 4.
- `clk` input 1: clock.
- `reset` input 1: asynchronous, active-high.
- `EX_MEM_flush` input 1: mispredict or exception flush; load `EX_MEM_redirect_pc`.
- `EX_MEM_redirect_pc` input 32: correct next PC, used with flush.
- `EX_MEM_stall` input 1: hold PC.
- `ID_EX_branch` input 1: jump resolved in ID/EX; load `ID_EX_target`.
- `ID_EX_target` input 32: jump target.
- `EX_MEM_br_valid` input 1: resolved conditional branch in EX/MEM.
- `EX_MEM_br_pc` input 32: PC of the resolved branch.
- `EX_MEM_br_taken` input 1: actual branch outcome.
- `inst_mem_read_data` input 32: combinational instruction read at `inst_mem_addr`.
- `inst_mem_addr` output 32: current PC.
- `IF_pc` output 32: current PC, forwarded for the IF/ID stage.
- `IF_take` output 1: the current instruction is a B-type branch predicted taken.

## Operation
- PC register: `inst_mem_addr = IF_pc = pc`, driven directly from the register.
- Predecode of `inst_mem_read_data`:
  - `is_b = (opcode == 7'b1100011)`.
  - `imm_b = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0}`.
  - JAL/JALR are not predicted; `ID_EX_branch` handles them.
- `IF_take = is_b & bht[idx][1]`, with `idx = pc[2 +: log2(BHT_ENTRIES)]`.
- Next-PC priority, highest first:
  1. `reset` → `RESET_PC`.
  2. `EX_MEM_flush` → `EX_MEM_redirect_pc`.
  3. `EX_MEM_stall` → `pc` (hold).
  4. `ID_EX_branch` → `ID_EX_target`.
  5. `IF_take` → `pc + imm_b`.
  6. Otherwise → `pc + 4`.
- PC arithmetic: 32-bit, wraps modulo 2^32. Bits [1:0] are forced to 0 on every load.
- BHT: `BHT_ENTRIES` 2-bit saturating counters; states SNT=00, WNT=01, WT=10, ST=11.
  - Update condition: `EX_MEM_br_valid & !EX_MEM_stall & !reset`, at index `EX_MEM_br_pc[2 +: log2]`.
  - Taken → increment, saturating at ST. Not taken → decrement, saturating at SNT.
  - Flush does not block the update, because the resolving branch itself is valid.
- Read/update of the same index in the same cycle: the read returns the pre-update value. The new value is visible from the next cycle.

## Timing
- Reset, asynchronous: `pc = RESET_PC` and all counters = WNT, immediately on assertion. Consequently `IF_take = 0` out of reset.
- Reset asserted mid-operation discards any pending redirect and all BHT training.
- PC latency: every next-PC decision takes effect at the next posedge. `inst_mem_addr` changes only on posedge or on reset.
- `IF_take` is combinational from `pc` and `inst_mem_read_data`, with zero-cycle latency. It is valid in the same cycle the IF/ID register samples it.
- Simultaneous events resolve strictly by the priority list; for example, flush + stall + `ID_EX_branch` in one cycle → `EX_MEM_redirect_pc`.
- Stall held for N cycles → the same PC is presented for N+1 cycles in total.
- The BHT has one write port, and training takes one cycle.

## Configuration
- Macro: `IF_BHT_EN`.
  - Defined: BHT instantiated; prediction as described above.
  - Undefined: no BHT storage; `IF_take` is tied to 0 (static not-taken); the predicted-taken next-PC path is absent. `EX_MEM_br_*` inputs are accepted and ignored. Everything else is identical.

## Structure
- Shared package `if_pkg` contains:
  - Opcode constants `OP_BRANCH` and `OP_JAL`.
  - Counter enum `bht_state_t` {SNT, WNT, WT, ST}.
  - Reset counter value `BHT_RESET = WNT`.
  - Function `imm_b()`.
- Sub-module `if_bht`:
  - Counter array with one asynchronous read port and one synchronous write port.
  - Owns the saturating-update logic.
  - Instantiated only under `IF_BHT_EN`.

## Test plan
1. **Reset sequencing:** `RESET_PC=0x100`, reset pulsed, no events → PC 0x100 with `IF_take=0`, then 0x104, then 0x108.
2. **Stall:** stall asserted for 2 cycles at PC 0x108 → 0x108 presented for 3 cycles, then 0x10C.
3. **Priority:** flush (redirect 0x200) + stall + `ID_EX_branch` (target 0x300) in the same cycle → PC 0x200. Next, `ID_EX_branch` alone with target 0x300 → 0x300.
4. **Training and predicted-taken (macro on):** two taken updates at `br_pc` 0x120 move WNT→WT→ST. Then fetch a B-type at 0x120 with imm +16 → `IF_take=1`, next PC 0x130.
5. **Saturation:** from ST, three not-taken updates → SNT; a fourth → stays SNT. At WT, an update colliding with a read of the same index → read shows WT, next cycle shows the new value.
6. **Macro off:** repeat scenario 4 → `IF_take=0`, next PC 0x124.

Source files
------------

// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: opcodes, BHT counter encoding and
// B-type immediate decode.
package if_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_t;

    localparam bht_state_t BHT_RESET = WNT;

    function automatic logic [31:0] imm_b(input logic [31:0] i);
        return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/if_bht.sv
// Branch history table: 2-bit saturating counters, one asynchronous read port and one
// synchronous write port. Only instantiated when IF_BHT_EN is defined.
module if_bht
    import if_pkg::*;
#(
    parameter int unsigned Entries = 64,
    localparam int unsigned IdxW   = $clog2(Entries)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [IdxW-1:0] rd_idx_i,
    output bht_state_t      rd_state_o,
    input  logic            upd_en_i,
    input  logic [IdxW-1:0] upd_idx_i,
    input  logic            upd_taken_i
);

    bht_state_t cnt_q [Entries];
    bht_state_t cnt_d;
    logic [1:0] cur;

    // Read sees the stored value, so a same-cycle update is only visible next cycle.
    assign rd_state_o = cnt_q[rd_idx_i];

    always_comb begin
        cur   = cnt_q[upd_idx_i];
        cnt_d = bht_state_t'(cur);
        if (upd_taken_i) begin
            if (cur != ST) cnt_d = bht_state_t'(cur + 2'd1);
        end else begin
            if (cur != SNT) cnt_d = bht_state_t'(cur - 2'd1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(Entries); i++) cnt_q[i] <= BHT_RESET;
        end else if (upd_en_i) begin
            cnt_q[upd_idx_i] <= cnt_d;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC selection and taken prediction for B-type
// branches. Define IF_BHT_EN to build the branch history table; otherwise static not-taken.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned BHT_ENTRIES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        EX_MEM_flush,
    input  logic [31:0] EX_MEM_redirect_pc,
    input  logic        EX_MEM_stall,
    input  logic        ID_EX_branch,
    input  logic [31:0] ID_EX_target,
    input  logic        EX_MEM_br_valid,
    input  logic [31:0] EX_MEM_br_pc,
    input  logic        EX_MEM_br_taken,
    input  logic [31:0] inst_mem_read_data,
    output logic [31:0] inst_mem_addr,
    output logic [31:0] IF_pc,
    output logic        IF_take
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        take;
    logic [31:0] taken_pc;
    logic        unused_bits;

    assign inst_mem_addr = pc_q;
    assign IF_pc         = pc_q;
    assign IF_take       = take;

`ifdef IF_BHT_EN
    localparam int unsigned IdxW = $clog2(BHT_ENTRIES);

    logic       is_b;
    bht_state_t pred;

    assign is_b = (inst_mem_read_data[6:0] == OP_BRANCH);

    if_bht #(
        .Entries(BHT_ENTRIES)
    ) u_bht (
        .clk        (clk),
        .reset      (reset),
        .rd_idx_i   (pc_q[2 +: IdxW]),
        .rd_state_o (pred),
        .upd_en_i   (EX_MEM_br_valid & ~EX_MEM_stall & ~reset),
        .upd_idx_i  (EX_MEM_br_pc[2 +: IdxW]),
        .upd_taken_i(EX_MEM_br_taken)
    );

    assign take     = is_b & pred[1];
    assign taken_pc = pc_q + imm_b(inst_mem_read_data);

    // JAL/JALR are resolved in ID/EX, never predicted here.
    assign unused_bits = ^{inst_mem_read_data[24:12], EX_MEM_br_pc,
                           (inst_mem_read_data[6:0] == OP_JAL)};
`else
    assign take     = 1'b0;
    assign taken_pc = '0;

    // Without a BHT the instruction word and resolved-branch bus have no consumer.
    assign unused_bits = ^{inst_mem_read_data, EX_MEM_br_valid, EX_MEM_br_pc,
                           EX_MEM_br_taken, BHT_ENTRIES[0], OP_BRANCH, OP_JAL};
`endif

    always_comb begin
        pc_d = pc_q + 32'd4;
        if (EX_MEM_flush) begin
            pc_d = EX_MEM_redirect_pc;
        end else if (EX_MEM_stall) begin
            pc_d = pc_q;
        end else if (ID_EX_branch) begin
            pc_d = ID_EX_target;
        end else if (take) begin
            pc_d = taken_pc;
        end
        pc_d[1:0] = 2'b00;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= {RESET_PC[31:2], 2'b00};
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule
